// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: definitions shared by the register file, dispatcher, ALU and
// the ALU reservation station.
//   DATA_W   operand width
//   TAG_W    ROB tag width
//   OP_W     ALU opcode width
//   TAG_FREE tag value meaning "operand value is valid"
//   alu_op_e ALU opcode encodings
package alu_rs_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 6;

  localparam logic [TAG_W-1:0] TAG_FREE = '0;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 6'h00,
    ALU_SUB  = 6'h01,
    ALU_AND  = 6'h02,
    ALU_OR   = 6'h03,
    ALU_XOR  = 6'h04,
    ALU_SLL  = 6'h05,
    ALU_SRL  = 6'h06,
    ALU_SRA  = 6'h07,
    ALU_SLT  = 6'h08,
    ALU_SLTU = 6'h09
  } alu_op_e;

endpackage

// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, CDB snoop and issue buses of the ALU reservation station.
//   master: dispatcher / CDB / ALU side (drives in_*, cdb_*, issue_ready)
//   slave : reservation station (drives full, issue_*)
interface alu_rs_if #(
  parameter int DATA_W = alu_rs_pkg::DATA_W,
  parameter int TAG_W  = alu_rs_pkg::TAG_W,
  parameter int OP_W   = alu_rs_pkg::OP_W
);

  logic              in_valid;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_data_o;
  logic [TAG_W-1:0]  in_tag_o;
  logic [DATA_W-1:0] in_data_t;
  logic [TAG_W-1:0]  in_tag_t;
  logic [TAG_W-1:0]  in_dst_tag;
  logic              full;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic [TAG_W-1:0]  issue_dst_tag;

  modport master (
    output in_valid, in_op, in_data_o, in_tag_o, in_data_t, in_tag_t, in_dst_tag,
    output cdb_valid, cdb_tag, cdb_data,
    output issue_ready,
    input  full, issue_valid, issue_op, issue_a, issue_b, issue_dst_tag
  );

  modport slave (
    input  in_valid, in_op, in_data_o, in_tag_o, in_data_t, in_tag_t, in_dst_tag,
    input  cdb_valid, cdb_tag, cdb_data,
    input  issue_ready,
    output full, issue_valid, issue_op, issue_a, issue_b, issue_dst_tag
  );

endinterface

// File: rtl/alu_rs_pick.sv
// rs_pick: lowest-index-set-bit priority encoder.
//   req   in  N      request vector
//   found out 1      any bit of req set
//   idx   out IW     index of the lowest set bit (0 when none)
module rs_pick #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: integer ALU reservation station.
//   clk, rst  clock, synchronous active-high reset
//   bus       alu_rs_if.slave: dispatch insert + full, CDB snoop,
//             valid/ready issue of the lowest-index ready entry
module alu_rs #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = alu_rs_pkg::DATA_W,
  parameter int TAG_W  = alu_rs_pkg::TAG_W,
  parameter int OP_W   = alu_rs_pkg::OP_W
) (
  input logic     clk,
  input logic     rst,
  alu_rs_if.slave bus
);
  import alu_rs_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_FREE);

  logic [DEPTH-1:0]  busy;
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [TAG_W-1:0]  dst_q   [DEPTH];
  logic [DATA_W-1:0] val_o_q [DEPTH];
  logic [TAG_W-1:0]  tag_o_q [DEPTH];
  logic [DATA_W-1:0] val_t_q [DEPTH];
  logic [TAG_W-1:0]  tag_t_q [DEPTH];

  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] rdy_vec;
  logic             free_found;
  logic             sel_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             cdb_hit;
  logic             do_insert;
  logic             do_issue;

  always_comb begin
    free_vec = ~busy;
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = busy[i] && (tag_o_q[i] == NO_TAG) && (tag_t_q[i] == NO_TAG);
    end
  end

  rs_pick #(.N(DEPTH), .IW(IDX_W)) u_free_pick (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_pick #(.N(DEPTH), .IW(IDX_W)) u_sel_pick (
    .req   (rdy_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // A zero CDB tag is never a producer, so it must not wake anything.
  assign cdb_hit   = bus.cdb_valid && (bus.cdb_tag != NO_TAG);
  assign do_insert = bus.in_valid && free_found;
  assign do_issue  = sel_found && bus.issue_ready;

  assign bus.full        = !free_found;
  assign bus.issue_valid = sel_found;
  // Data outputs are forced to zero when nothing is presented.
  assign bus.issue_op      = sel_found ? op_q[sel_idx]    : '0;
  assign bus.issue_a       = sel_found ? val_o_q[sel_idx] : '0;
  assign bus.issue_b       = sel_found ? val_t_q[sel_idx] : '0;
  assign bus.issue_dst_tag = sel_found ? dst_q[sel_idx]   : '0;

  // Wakeup only touches busy slots and insert only a free one, so the
  // two never write the same entry in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        dst_q[i]   <= '0;
        val_o_q[i] <= '0;
        tag_o_q[i] <= NO_TAG;
        val_t_q[i] <= '0;
        tag_t_q[i] <= NO_TAG;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && cdb_hit && (tag_o_q[i] == bus.cdb_tag)) begin
          val_o_q[i] <= bus.cdb_data;
          tag_o_q[i] <= NO_TAG;
        end
        if (busy[i] && cdb_hit && (tag_t_q[i] == bus.cdb_tag)) begin
          val_t_q[i] <= bus.cdb_data;
          tag_t_q[i] <= NO_TAG;
        end
        if (do_issue && (sel_idx == IDX_W'(i))) begin
          busy[i] <= 1'b0;
        end
        if (do_insert && (free_idx == IDX_W'(i))) begin
          busy[i]  <= 1'b1;
          op_q[i]  <= bus.in_op;
          dst_q[i] <= bus.in_dst_tag;
          if (cdb_hit && (bus.in_tag_o == bus.cdb_tag)) begin
            val_o_q[i] <= bus.cdb_data;
            tag_o_q[i] <= NO_TAG;
          end else begin
            val_o_q[i] <= bus.in_data_o;
            tag_o_q[i] <= bus.in_tag_o;
          end
          if (cdb_hit && (bus.in_tag_t == bus.cdb_tag)) begin
            val_t_q[i] <= bus.cdb_data;
            tag_t_q[i] <= NO_TAG;
          end else begin
            val_t_q[i] <= bus.in_data_t;
            tag_t_q[i] <= bus.in_tag_t;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios followed by random traffic, every cycle
// checked against a behavioural model of the reservation station.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_rs_if bus ();

  alu_rs #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [3:0]  dst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ta;
    logic [3:0]  tb;
  } ent_t;

  ent_t m[DEPTH];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_sel();
    for (int i = 0; i < DEPTH; i++)
      if (m[i].busy && m[i].ta == 4'd0 && m[i].tb == 4'd0) return i;
    return -1;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < DEPTH; i++)
      if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m[i].busy = 1'b0;
      m[i].ta   = 4'd0;
      m[i].tb   = 4'd0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_update(input int sel);
    bit hit;
    bit was_full;
    int slot;
    if (rst) begin
      model_clear();
      return;
    end
    hit = bus.cdb_valid && bus.cdb_tag != 4'd0;
    was_full = model_full();
    slot = -1;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!m[i].busy) slot = i;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy && hit && m[i].ta == bus.cdb_tag) begin
        m[i].a = bus.cdb_data; m[i].ta = 4'd0;
      end
      if (m[i].busy && hit && m[i].tb == bus.cdb_tag) begin
        m[i].b = bus.cdb_data; m[i].tb = 4'd0;
      end
    end
    if (sel >= 0 && bus.issue_ready) m[sel].busy = 1'b0;
    if (bus.in_valid && !was_full) begin
      m[slot].busy = 1'b1;
      m[slot].op   = bus.in_op;
      m[slot].dst  = bus.in_dst_tag;
      if (hit && bus.in_tag_o == bus.cdb_tag) begin
        m[slot].a = bus.cdb_data; m[slot].ta = 4'd0;
      end else begin
        m[slot].a = bus.in_data_o; m[slot].ta = bus.in_tag_o;
      end
      if (hit && bus.in_tag_t == bus.cdb_tag) begin
        m[slot].b = bus.cdb_data; m[slot].tb = 4'd0;
      end else begin
        m[slot].b = bus.in_data_t; m[slot].tb = bus.in_tag_t;
      end
    end
  endtask

  // Check outputs mid-cycle, then advance model and DUT one edge.
  task automatic tick();
    int s;
    #3;
    s = model_sel();
    chk("full", 32'(bus.full), 32'(model_full()));
    chk("issue_valid", 32'(bus.issue_valid), (s >= 0) ? 32'd1 : 32'd0);
    if (s >= 0) begin
      chk("issue_op", 32'(bus.issue_op), 32'(m[s].op));
      chk("issue_a", bus.issue_a, m[s].a);
      chk("issue_b", bus.issue_b, m[s].b);
      chk("issue_dst_tag", 32'(bus.issue_dst_tag), 32'(m[s].dst));
    end
    model_update(s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.cdb_valid = 1'b0;
  endtask

  task automatic ins(input logic [5:0] op, input logic [31:0] a, input logic [3:0] ta,
                     input logic [31:0] b, input logic [3:0] tb, input logic [3:0] dst);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_data_o  = a;
    bus.in_tag_o   = ta;
    bus.in_data_t  = b;
    bus.in_tag_t   = tb;
    bus.in_dst_tag = dst;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_data_o = '0; bus.in_tag_o = '0;
    bus.in_data_t = '0; bus.in_tag_t = '0; bus.in_dst_tag = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.issue_ready = 1'b1;
    model_clear();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state of the outputs
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_valid", 32'(bus.issue_valid), 32'd0);
    chk("rst_op", 32'(bus.issue_op), 32'd0);
    chk("rst_a", bus.issue_a, 32'd0);
    chk("rst_b", bus.issue_b, 32'd0);
    chk("rst_dst", 32'(bus.issue_dst_tag), 32'd0);

    // Ready-at-insert ADD issues next cycle and frees on handshake
    ins(ALU_ADD, 32'd5, 4'd0, 32'd7, 4'd0, 4'd3); tick();
    idle(); tick(); tick();

    // Operand o waits on tag 2, woken two cycles later
    ins(ALU_SUB, 32'hdead, 4'd2, 32'd1, 4'd0, 4'd5); tick();
    idle(); tick(); tick();
    cdb(4'd2, 32'h10); tick();
    idle(); tick(); tick();

    // Insert-time capture of operand t from a simultaneous broadcast
    ins(ALU_OR, 32'd3, 4'd0, 32'd0, 4'd4, 4'd6); cdb(4'd4, 32'd9); tick();
    idle(); tick(); tick();

    // Fill all slots with pending operands; extra insert ignored while full
    bus.issue_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ins(ALU_XOR, 32'(i), 4'(i + 1), 32'(100 + i), 4'd0, 4'(i)); tick();
    end
    ins(ALU_AND, 32'hbad, 4'd0, 32'hbad, 4'd0, 4'd15); tick(); tick();
    idle(); cdb(4'd6, 32'h66); tick();
    idle(); tick(); tick(); tick();
    // Drain the rest
    for (int t = 1; t <= DEPTH; t++) begin
      cdb(4'(t), 32'(t * 3)); tick();
    end
    idle(); tick(); tick(); tick();

    // Entries 1 and 6 ready while the ALU stalls; lower index must hold
    for (int i = 0; i < DEPTH; i++) begin
      ins(ALU_SLT, 32'(i), 4'(i + 1), 32'(i * 2), 4'd0, 4'(i)); tick();
    end
    bus.issue_ready = 1'b0;
    idle(); cdb(4'd7, 32'h77); tick();
    cdb(4'd2, 32'h22); tick();
    idle(); tick(); tick(); tick();
    bus.issue_ready = 1'b1; tick(); tick(); tick();
    for (int t = 1; t <= DEPTH; t++) begin
      cdb(4'(t), 32'(t)); tick();
    end
    idle(); tick(); tick(); tick();

    // Reset with busy entries and one presented
    ins(ALU_ADD, 32'd1, 4'd10, 32'd2, 4'd0, 4'd1); tick();
    ins(ALU_ADD, 32'd3, 4'd11, 32'd4, 4'd0, 4'd2); tick();
    ins(ALU_ADD, 32'd5, 4'd0, 32'd6, 4'd12, 4'd3); tick();
    bus.issue_ready = 1'b0;
    ins(ALU_ADD, 32'd7, 4'd0, 32'd8, 4'd0, 4'd4); tick();
    rst = 1'b1; ins(ALU_SUB, 32'd9, 4'd0, 32'd9, 4'd0, 4'd9); tick();
    rst = 1'b0; idle(); bus.issue_ready = 1'b1; tick();
    cdb(4'd10, 32'haa); tick();
    idle(); tick(); tick();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bus.in_valid   = ($urandom_range(0, 2) != 0);
      bus.in_op      = 6'($urandom_range(0, 9));
      bus.in_data_o  = $urandom;
      bus.in_tag_o   = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 15));
      bus.in_data_t  = $urandom;
      bus.in_tag_t   = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 15));
      bus.in_dst_tag = 4'($urandom_range(0, 15));
      bus.cdb_valid  = ($urandom_range(0, 1) != 0);
      bus.cdb_tag    = 4'($urandom_range(0, 15));
      bus.cdb_data   = $urandom;
      bus.issue_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle(); bus.issue_ready = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the integer ALU in the Tomasulo back end. It accepts renamed instructions from the dispatcher, each carrying operands as a value or a producer tag, as read from the register file. It snoops the common data bus (CDB) to capture pending operands, and issues one fully-ready instruction per cycle to the ALU under a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 8: number of entries (power of two, ≥2)
- DATA_W, 32: operand width
- TAG_W, 4: ROB tag width
- OP_W, 6: ALU opcode width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  dispatcher inserts an instruction this cycle
- in_op  in  OP_W  ALU opcode
- in_data_o / in_tag_o  in  DATA_W / TAG_W  operand 1 value / producer tag
- in_data_t / in_tag_t  in  DATA_W / TAG_W  operand 2 value / producer tag
- in_dst_tag  in  TAG_W  tag the result will be broadcast under
- full  out  1  no free entry; dispatcher must not assert in_valid
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  DATA_W  broadcast value
- issue_valid  out  1  a ready entry is presented
- issue_ready  in  1  ALU accepts this cycle
- issue_op  out  OP_W  opcode of the presented entry
- issue_a / issue_b  out  DATA_W  operand values
- issue_dst_tag  out  TAG_W  destination tag

## Operation
- Entry state: busy, op, dst_tag, and for each operand a value and a tag. A tag equal to TAG_FREE (all-zero) means the value is valid.
- Insert: when in_valid is high and full is low, the entry is written into the lowest-index non-busy slot and becomes busy. If in_valid is high while full is high, the insert is ignored and the state is unchanged.
- Insert-time capture: if cdb_valid is high and cdb_tag equals in_tag_o (non-free), the slot stores cdb_data with TAG_FREE for that operand. The same rule applies to operand t.
- Wakeup: each cycle, every busy entry whose operand tag equals cdb_tag (cdb_valid high, tag non-free) latches cdb_data and sets the tag to TAG_FREE.
- Ready: an entry is ready when it is busy and both operand tags equal TAG_FREE, using registered state only.
- Select: issue outputs present the lowest-index ready entry, combinationally from registered state. issue_valid is 0 when no entry is ready.
- Issue: when issue_valid and issue_ready are both high, the selected entry's busy bit clears at the clock edge.
- Output values: the issue_* data outputs are don't-care when issue_valid is 0. The bench compares them only when issue_valid is high.

## Timing
- Reset: all busy bits cleared and all tags set to TAG_FREE. Outputs: full=0, issue_valid=0, issue_op=0, issue_a=0, issue_b=0, issue_dst_tag=0. Reset overrides a simultaneous insert or issue.
- Insert with operands already free: issue_valid can rise the cycle after insertion (1-cycle minimum latency).
- CDB wakeup at edge N: the entry is issuable from cycle N+1. There is no same-cycle bypass from the CDB to the issue outputs.
- full is computed from the registered busy bits only. A slot freed by issue in cycle N is visible as free from cycle N+1. Insert and issue in the same cycle are legal; the insert targets a slot that was free before the edge.
- Holding: while issue_ready is low, the same entry stays presented, unless a lower-index entry becomes ready, in which case selection switches to it.
- Tag matching never matches TAG_FREE. A cdb_tag of 0 is ignored.

## Structure
- Shared package/defines: TAG_W, TAG_FREE, DATA_W, OP_W and the ALU opcode constants. These are shared with the register file, the dispatcher and the ALU.
- One sub-module, rs_pick: a parameterised lowest-index-set-bit priority encoder producing a found flag and an index. It is instantiated twice: once for free-slot search (over ~busy) and once for ready select.

## Test plan
- Reset then insert op=ADD, a=5/tag0, b=7/tag0, dst=3 with issue_ready=1 → issue_valid=1 on the next cycle with a=5, b=7, dst_tag=3; the entry frees after the handshake.
- Insert with tag_o=2 pending; CDB broadcasts tag 2, data 0x10, two cycles later → issue_valid=1 in the cycle after the broadcast with issue_a=0x10.
- Insert with tag_t=4 in the same cycle as a CDB broadcast of tag 4, data 9 → the entry captures 9 and issues the next cycle.
- Fill 8 entries with pending tags → full=1. A ninth in_valid is ignored. Broadcast a tag that wakes entry 5 → that entry issues, and full drops the cycle after the handshake.
- Entries 1 and 6 ready with issue_ready=0 for 3 cycles → entry 1 is held stable for those 3 cycles. Then issue_ready=1 → entry 1 issues, followed by entry 6.
- Assert rst with 4 busy entries and issue_valid=1 → full=0 and issue_valid=0 the next cycle, and a prior-pending CDB tag broadcast afterwards causes no issue.
